// File: rtl/aes_dec_round_ctrl.sv
// AES-128 inverse-cipher round controller.
// Holds the 128-bit cipher state, walks the round-key index from NR down to 0,
// and feeds the external inverse-round datapath one round per clock. The block
// enters through a valid/ready input port and leaves through a valid/ready
// output port; abort flushes the sequence back to IDLE at any time.
module aes_dec_round_ctrl #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [KIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk_data,
  output logic [127:0]      dp_state,
  output logic              dp_last,
  input  logic [127:0]      dp_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy,
  input  logic              abort
);

  localparam int DATA_W = 128;

  // Key index used for the initial AddRoundKey while waiting in IDLE.
  localparam logic [KIDX_W-1:0] LAST_IDX  = KIDX_W'(NR);
  // Round counter value loaded on accept: the first full inverse round uses key NR-1.
  localparam logic [KIDX_W-1:0] FIRST_CNT = KIDX_W'(NR - 1);
  localparam logic [KIDX_W-1:0] CNT_ONE   = KIDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              fsm_q, fsm_d;
  logic [KIDX_W-1:0]   round_cnt_q, round_cnt_d;
  logic [DATA_W-1:0]   state_q, state_d;

  // Next-state, counter, state-register and handshake decode.
  always_comb begin
    fsm_d       = fsm_q;
    round_cnt_d = round_cnt_q;
    state_d     = state_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    rk_idx      = round_cnt_q;
    dp_last     = 1'b0;
    dp_state    = state_q;
    out_data    = state_q;

    case (fsm_q)
      IDLE: begin
        // in_ready depends only on the registered FSM state, never on out_ready.
        in_ready = 1'b1;
        busy     = 1'b0;
        rk_idx   = LAST_IDX;
        if (in_valid) begin
          // Initial AddRoundKey with round key NR happens on the accept edge.
          state_d     = in_data ^ rk_data;
          round_cnt_d = FIRST_CNT;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        // Round 0 is the final round: the datapath skips InvMixColumns.
        dp_last = (round_cnt_q == '0);
        state_d = dp_result;
        if (round_cnt_q == '0) begin
          fsm_d = DONE;
        end else begin
          round_cnt_d = round_cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        // Plaintext is the state register itself, held until the sink takes it.
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d       = IDLE;
        round_cnt_d = '0;
      end
    endcase

    // abort wins over any accept or output handshake in the same cycle and
    // leaves the state register untouched.
    if (abort) begin
      fsm_d       = IDLE;
      round_cnt_d = '0;
      state_d     = state_q;
    end
  end

  // FSM and round counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      round_cnt_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  // 128-bit cipher state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Self-checking bench for aes_dec_round_ctrl: models the key store and the
// inverse-round datapath, and checks plaintexts against a forward AES-128
// encryption reference through a scoreboard queue.
`timescale 1ns/1ps
module tb_aes_dec_round_ctrl;

  localparam int NR     = 10;
  localparam int KIDX_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [127:0]      in_data = '0;
  logic [KIDX_W-1:0] rk_idx;
  logic [127:0]      rk_data;
  logic [127:0]      dp_state;
  logic              dp_last;
  logic [127:0]      dp_result;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [127:0]      out_data;
  logic              busy;
  logic              abort = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = -1;
  int last_hs = -1;
  bit rnd_rdy = 1'b0;

  logic [127:0] exp_q[$];
  logic [7:0]   sbox[256];
  logic [7:0]   isbox[256];
  logic [127:0] rk_tab[16];

  aes_dec_round_ctrl #(.NR(NR), .KIDX_W(KIDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk_data(rk_data),
    .dp_state(dp_state), .dp_last(dp_last), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [7:0] r;
    r = (b << k) | (b >> (8 - k));
    return r;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] pb(input logic [127:0] v, input int i, input logic [7:0] b);
    logic [127:0] r;
    r = v;
    r[127-8*i -: 8] = b;
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      p = 8'h01;
      for (int k = 0; k < 254; k++) p = gmul(p, b);
      sbox[i] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [127:0] mix(input logic [127:0] v, input bit inv);
    logic [7:0] m[4];
    logic [7:0] acc;
    logic [127:0] r;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - row + 4) % 4], gb(v, j + 4*c));
        r = pb(r, row + 4*c, acc);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r = pb(r, row + 4*c, sbox[gb(v, row + 4*((c + row) % 4))]);
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r = pb(r, row + 4*((c + row) % 4), isbox[gb(v, row + 4*c)]);
    return r;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t;
    t = inv_shift_sub(s) ^ k;
    return last ? t : mix(t, 1'b1);
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_tab[0];
    for (int r = 1; r < NR; r++) s = mix(sub_shift(s), 1'b0) ^ rk_tab[r];
    return sub_shift(s) ^ rk_tab[NR];
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w[4*(NR+1)];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Key store and datapath models.
  assign rk_data   = rk_tab[rk_idx];
  assign dp_result = inv_round(dp_state, rk_data, dp_last);

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard monitor: pops the expected plaintext on every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) chk("rk_idx_range", {127'b0, (int'(rk_idx) <= NR)}, 128'd1);
      if (out_valid && out_ready && !abort) begin
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_output: got %h expected none", out_data);
        end else begin
          chk("sb_plaintext", out_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drop_last();
    if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit keep, output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_data = ct;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !abort && rst_n) begin
        exp_q.push_back(pt);
        last_acc = cyc;
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          fail_now("accept_timeout");
          done = 1'b1;
        end
      end
      tick();
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("out_valid_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || busy) fail_now("drain_timeout");
  endtask

  task automatic fips_run();
    int w;
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fips_idle_rk_idx", rk_idx, NR);
    chk("fips_idle_in_ready", in_ready, 1);
    tick();
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1'b0, w);
    for (int k = 1; k <= NR; k++) begin
      @(negedge clk);
      chk("fips_rk_idx_seq", rk_idx, NR - k);
      chk("fips_dp_last", dp_last, (k == NR) ? 1 : 0);
      chk("fips_round_busy", {busy, in_ready, out_valid}, 3'b100);
    end
    @(negedge clk);
    chk("fips_out_valid", out_valid, 1);
    chk("fips_done_dp_last", dp_last, 0);
    chk("fips_latency", cyc - last_acc, NR + 1);
    tick();
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt1, pt2, ct1, ct2, snap;
    logic [KIDX_W-1:0] ri;
    int w, w2, a1, a2;
    bit seen;

    build_sbox();
    set_key(128'h000102030405060708090a0b0c0d0e0f);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rk_idx", rk_idx, NR);
    chk("rst_dp_last", dp_last, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Known-answer vector.
    fips_run();

    // Back-to-back blocks with in_valid held high.
    out_ready = 1'b1;
    pt1 = rnd128(); pt2 = rnd128();
    ct1 = encrypt(pt1); ct2 = encrypt(pt2);
    send(ct1, pt1, 1'b1, w);
    a1 = last_acc;
    send(ct2, pt2, 1'b0, w2);
    a2 = last_acc;
    chk("b2b_in_ready_low_cycles", w2, NR + 1);
    chk("b2b_accept_after_hs", a2 - last_hs, 1);
    chk("b2b_period", a2 - a1, NR + 2);
    drain();

    // Output backpressure.
    out_ready = 1'b0;
    pt1 = rnd128();
    send(encrypt(pt1), pt1, 1'b0, w);
    wait_out_valid();
    snap = out_data;
    ri = rk_idx;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = rnd128();
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, snap);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_rk_idx", rk_idx, ri);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_queue_empty", exp_q.size(), 0);
    tick();

    // Abort at the round_cnt==5 cycle.
    out_ready = 1'b1;
    pt1 = rnd128();
    send(encrypt(pt1), pt1, 1'b0, w);
    w = 0;
    while (rk_idx != 4'd5 && w < 20) begin
      tick();
      w++;
    end
    if (rk_idx != 4'd5) fail_now("abort_round5_wait");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    drop_last();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_rk_idx", rk_idx, NR);
    seen = out_valid;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort_no_out_valid", seen, 0);
    tick();
    fips_run();

    // Asynchronous reset while holding in DONE.
    out_ready = 1'b0;
    pt1 = rnd128();
    send(encrypt(pt1), pt1, 1'b0, w);
    wait_out_valid();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rk_idx", rk_idx, NR);
    chk("arst_out_data", out_data, 0);
    drop_last();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    pt2 = rnd128();
    send(encrypt(pt2), pt2, 1'b0, w);
    chk("arst_first_accept_wait", w, 0);
    drain();

    // abort together with in_valid in IDLE.
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = rnd128();
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_in_ready", in_ready, 1);
    chk("abort_idle_rk_idx", rk_idx, NR);
    chk("abort_idle_queue", exp_q.size(), 0);
    tick();

    // Randomized blocks, keys and output backpressure.
    rnd_rdy = 1'b1;
    for (int b = 0; b < 25; b++) begin
      if (b % 5 == 0) begin
        drain();
        set_key(rnd128());
      end
      repeat ($urandom_range(0, 3)) tick();
      pt1 = rnd128();
      send(encrypt(pt1), pt1, 1'b0, w);
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
